// File: rtl/fnc_vram_writer_if.sv
// rtl/fnc_vram_writer_if.sv - pixel write request channel into the VRAM writer
interface fnc_vram_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [18:0] req_addr;
  logic [11:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/fnc_vram_writer.sv
// rtl/fnc_vram_writer.sv - VRAM write-side agent: pixel request FIFO plus clear-screen engine
module fnc_vram_writer #(
  parameter int FB_SIZE    = 307200,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    module_en,
  fnc_vram_writer_if.slave        req,
  input  logic                    clr_start,
  input  logic [11:0]             clr_color,
  output logic                    clr_done,
  output logic                    busy,
  output logic                    wr_err,
  input  logic                    err_clr,
  output logic                    vram_we,
  output logic [18:0]             vram_addr,
  output logic [11:0]             vram_wdata
);

  localparam logic [18:0] FB_SIZE_W = 19'(FB_SIZE);
  localparam logic [18:0] FB_LAST   = 19'(FB_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR_WAIT,
    CLEAR
  } state_t;

  state_t           state;
  logic [30:0]      fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             accept;
  logic             addr_ok;
  logic             push;
  logic             pop;
  logic [30:0]      head;
  logic [18:0]      count;
  logic [11:0]      clr_color_q;
  logic             clr_last;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign req.req_ready = ~rst & module_en & ~fifo_full & (state == IDLE);
  assign accept        = req.req_valid & req.req_ready;
  assign addr_ok       = (req.req_addr < FB_SIZE_W);
  assign push          = accept & addr_ok;

  // The FIFO keeps draining while a clear waits for it; only CLEAR owns the port.
  assign pop  = ~rst & module_en & ~fifo_empty & (state != CLEAR);
  assign head = fifo_mem[rd_ptr[FIFO_AW-1:0]];

  assign busy = (state != IDLE) | ~fifo_empty | vram_we;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {req.req_addr, req.req_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !module_en) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      clr_color_q <= '0;
      clr_last    <= 1'b0;
      clr_done    <= 1'b0;
      vram_we     <= 1'b0;
      vram_addr   <= '0;
      vram_wdata  <= '0;
      // Disabling the block keeps the sticky error so software can still read it.
      if (rst || err_clr) begin
        wr_err <= 1'b0;
      end
    end else begin
      clr_done <= clr_last;
      clr_last <= 1'b0;
      vram_we  <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        vram_we    <= 1'b1;
        vram_addr  <= head[30:12];
        vram_wdata <= head[11:0];
      end

      if (accept && !addr_ok) begin
        wr_err <= 1'b1;
      end else if (err_clr) begin
        wr_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (clr_start) begin
            clr_color_q <= clr_color;
            state       <= CLR_WAIT;
          end
        end
        CLR_WAIT: begin
          if (fifo_empty) begin
            count <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          vram_we    <= 1'b1;
          vram_addr  <= count;
          vram_wdata <= clr_color_q;
          if (count == FB_LAST) begin
            count    <= '0;
            clr_last <= 1'b1;
            state    <= IDLE;
          end else begin
            count <= count + 19'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
